// File: rtl/serial_add_ctrl_pkg.sv
// adder_pkg: shared types and constants for the serial adder controller.
//   state_t   - controller FSM states (IDLE, RUN, DONE)
//   ADD_WIDTH - default operand width
package adder_pkg;

    localparam int ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: purely combinational 1-bit full adder.
// Ports:
//   a, b, cin - addend bits and carry in
//   s, cout   - sum bit and carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder built around one fa_cell,
// LSB first, one bit per clock.
//
// state | meaning
// IDLE  | req_ready = 1, waiting for an operand pair
// RUN   | one bit per clock through the shared full-adder cell
// DONE  | rsp_valid = 1, result held until rsp_ready
//
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   req_valid/req_ready   - operand handshake; op_a, op_b sampled at accept
//   rsp_valid/rsp_ready   - result handshake
//   rsp_sum/carry/ovf     - registered sum, carry out of MSB, signed overflow
// Optional macro SERIAL_ADD_SUB_EN: adds op_sub input (1 = compute A - B,
// rsp_carry = 1 means no borrow).
module serial_add_ctrl
    import adder_pkg::*;
#(
    parameter  int WIDTH = ADD_WIDTH,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             op_sub,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_carry,
    output logic             rsp_ovf
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_nxt;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             b_bit;
    logic             s;
    logic             co;
    logic             last;
    logic             init_c;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_r;

    // Subtraction is A + ~B + 1: invert each b bit and seed the carry.
    assign b_bit  = b_sr[0] ^ sub_r;
    assign init_c = op_sub;
`else
    assign b_bit  = b_sr[0];
    assign init_c = 1'b0;
`endif

    fa_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_bit),
        .cin  (c),
        .s    (s),
        .cout (co)
    );

    assign last      = (cnt == CNT_W'(WIDTH - 1));
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);

    // Written as shift-then-overwrite so it stays legal for WIDTH = 1.
    always_comb begin
        sum_nxt            = sum_sr >> 1;
        sum_nxt[WIDTH-1]   = s;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            cnt       <= '0;
            c         <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_sr   <= op_a;
                        b_sr   <= op_b;
                        sum_sr <= '0;
                        cnt    <= '0;
                        c      <= init_c;
`ifdef SERIAL_ADD_SUB_EN
                        sub_r  <= op_sub;
`endif
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_nxt;
                    c      <= co;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        rsp_sum   <= sum_nxt;
                        rsp_carry <= co;
                        // c is the carry into the MSB on the last bit
                        rsp_ovf   <= c ^ co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_carry;
    logic         rsp_ovf;
`ifdef SERIAL_ADD_SUB_EN
    logic         op_sub;
`endif

    int checks;
    int errors;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef SERIAL_ADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_ovf   (rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } vec_t;

    vec_t add_vecs[9];
`ifdef SERIAL_ADD_SUB_EN
    vec_t sub_vecs[3];
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits (bounded) after the accept edge for rsp_valid; returns edge count.
    task automatic wait_rsp(output int edges);
        edges = 0;
        while (!rsp_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic do_op(input string name, input vec_t v);
        int edges;
        @(negedge clk);
        check({name, " req_ready"}, 32'(req_ready), 32'd1);
        op_a      = v.a;
        op_b      = v.b;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op_a      = ~v.a;
        op_b      = v.b ^ 8'h5A;
        wait_rsp(edges);
        check({name, " latency"}, 32'(edges), 32'(W));
        check({name, " sum"},     32'(rsp_sum),   32'(v.sum));
        check({name, " carry"},   32'(rsp_carry), 32'(v.carry));
        check({name, " ovf"},     32'(rsp_ovf),   32'(v.ovf));
        @(posedge clk);
        #1;
        check({name, " valid drop"}, 32'(rsp_valid), 32'd0);
        check({name, " sum held"},   32'(rsp_sum),   32'(v.sum));
    endtask

    initial begin
        int   edges;
        vec_t v;
        checks = 0;
        errors = 0;

        add_vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
        add_vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        add_vecs[2] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        add_vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        add_vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        add_vecs[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
        add_vecs[6] = '{8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0};
        add_vecs[7] = '{8'h40, 8'h40, 8'h80, 1'b0, 1'b1};
        add_vecs[8] = '{8'h3C, 8'hA5, 8'hE1, 1'b0, 1'b0};
`ifdef SERIAL_ADD_SUB_EN
        sub_vecs[0] = '{8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        sub_vecs[1] = '{8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        sub_vecs[2] = '{8'h10, 8'h10, 8'h00, 1'b1, 1'b0};
        op_sub      = 1'b0;
`endif

        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        #12;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_sum",   32'(rsp_sum),   32'd0);
        check("reset rsp_carry", 32'(rsp_carry), 32'd0);
        check("reset rsp_ovf",   32'(rsp_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) do_op($sformatf("add%0d", i), add_vecs[i]);

        // Backpressure: result held in DONE, queued request waits.
        @(negedge clk);
        op_a      = 8'h0F;
        op_b      = 8'h01;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        op_a = 8'h22;
        op_b = 8'h33;
        wait_rsp(edges);
        check("bp latency", 32'(edges), 32'(W));
        for (int k = 0; k < 5; k++) begin
            check("bp valid",     32'(rsp_valid), 32'd1);
            check("bp req_ready", 32'(req_ready), 32'd0);
            check("bp sum",       32'(rsp_sum),   32'h10);
            check("bp carry",     32'(rsp_carry), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp handshake valid", 32'(rsp_valid), 32'd0);
        check("bp handshake ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp second accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        op_a      = 8'hAA;
        op_b      = 8'hAA;
        wait_rsp(edges);
        check("bp2 latency", 32'(edges), 32'(W));
        check("bp2 sum",     32'(rsp_sum),   32'h55);
        check("bp2 carry",   32'(rsp_carry), 32'd0);
        check("bp2 ovf",     32'(rsp_ovf),   32'd0);
        @(posedge clk);
        #1;

        // Reset mid-RUN after 4 bit cycles.
        @(negedge clk);
        op_a      = 8'hAA;
        op_b      = 8'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre-reset busy", 32'(req_ready), 32'd0);
        check("pre-reset sum",  32'(rsp_sum),   32'h55);
        rst_n = 1'b0;
        #1;
        check("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid reset req_ready", 32'(req_ready), 32'd1);
        check("mid reset rsp_sum",   32'(rsp_sum),   32'd0);
        check("mid reset rsp_carry", 32'(rsp_carry), 32'd0);
        check("mid reset rsp_ovf",   32'(rsp_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post reset rsp_valid", 32'(rsp_valid), 32'd0);
        v = '{8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
        do_op("after reset", v);

`ifdef SERIAL_ADD_SUB_EN
        op_sub = 1'b1;
        for (int i = 0; i < 3; i++) do_op($sformatf("sub%0d", i), sub_vecs[i]);
        op_sub = 1'b0;
        v = '{8'h05, 8'h07, 8'h0C, 1'b0, 1'b0};
        do_op("add after sub", v);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
